// File: rtl/rtc_pkg.sv
// rtc_pkg: shared types and default timing for the RTC bus-cycle generator.
//   rtc_state_t : bus-cycle FSM states
//   rtc_op_t    : transaction type (OP_WR / OP_RD)
//   DEF_T_*     : default phase lengths in clk cycles
package rtc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_A_SETUP = 4'd1,
        ST_A_PULSE = 4'd2,
        ST_A_HOLD  = 4'd3,
        ST_D_SETUP = 4'd4,
        ST_D_PULSE = 4'd5,
        ST_D_HOLD  = 4'd6,
        ST_DONE    = 4'd7,
        ST_REC     = 4'd8
    } rtc_state_t;

    typedef enum logic {
        OP_WR = 1'b0,
        OP_RD = 1'b1
    } rtc_op_t;

    localparam int unsigned DEF_T_SETUP = 2;
    localparam int unsigned DEF_T_PULSE = 4;
    localparam int unsigned DEF_T_HOLD  = 2;
    localparam int unsigned DEF_T_REC   = 2;

endpackage

// File: rtl/rtc_bus_ctrl_phase_timer.sv
// rtc_phase_timer: loadable 8-bit down-counter timing one FSM phase.
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   load      in   reload the counter with load_val
//   load_val  in   phase length minus one
//   expired   out  terminal count reached (count == 0)
// The counter stops at zero instead of wrapping, so a phase that is not left
// on expiry simply stays expired.
module rtc_phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       expired
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign expired = (count == 8'd0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: bus-cycle generator for the RTC multiplexed address/data bus.
// Each request runs an address phase then a data phase (setup/strobe/hold each),
// pulses fin once, then waits out a recovery window before sampling again.
//   clk, reset          clock, asynchronous active-low reset
//   escribe, lee        write / read request levels (sampled only in IDLE)
//   dir, dato           register address / write data
//   ad_in               pad read-back
//   ad_out, ad_oe       bus drive value and output enable
//   ad_sel              0 = address phase, 1 = data phase
//   cs_n, wr_n, rd_n    active-low chip select and strobes
//   dato_leido          last read data
//   fin                 one-cycle completion pulse
//   ocupado             high whenever the FSM is not IDLE
// Build option: RTC_READ_EN enables the read path. Without it lee is ignored,
// rd_n stays 1 and dato_leido stays 0.
//
// state    | meaning
// ---------+----------------------------------------------
// IDLE     | waiting for escribe/lee, latches dir/dato/op
// A_SETUP  | address driven, cs_n low, strobe inactive
// A_PULSE  | address strobe (wr_n low)
// A_HOLD   | address held after strobe release
// D_SETUP  | data phase setup (ad_sel=1)
// D_PULSE  | wr_n low (write) or rd_n low (read)
// D_HOLD   | data held after strobe release
// DONE     | fin pulse, bus released
// REC      | recovery, requests ignored
module rtc_bus_ctrl
    import rtc_pkg::*;
#(
    parameter int unsigned T_SETUP = DEF_T_SETUP,
    parameter int unsigned T_PULSE = DEF_T_PULSE,
    parameter int unsigned T_HOLD  = DEF_T_HOLD,
    parameter int unsigned T_REC   = DEF_T_REC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       escribe,
    input  logic       lee,
    input  logic [7:0] dir,
    input  logic [7:0] dato,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       ad_sel,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic [7:0] dato_leido,
    output logic       fin,
    output logic       ocupado
);

    rtc_state_t state, state_nx;
    rtc_op_t    op_q, op_nx;
    logic [7:0] dir_q, dir_nx, dato_q, dato_nx;
    logic       expired, load;
    logic [7:0] load_val;
    logic       lee_req;

    logic [7:0] ad_out_nx;
    logic       ad_oe_nx, ad_sel_nx, cs_n_nx, wr_n_nx, rd_n_nx, fin_nx, ocupado_nx;

`ifdef RTC_READ_EN
    assign lee_req = lee;
`else
    assign lee_req = 1'b0;
`endif

    function automatic logic [7:0] phase_last(input rtc_state_t s);
        case (s)
            ST_A_SETUP, ST_D_SETUP: phase_last = 8'(T_SETUP - 1);
            ST_A_PULSE, ST_D_PULSE: phase_last = 8'(T_PULSE - 1);
            ST_A_HOLD,  ST_D_HOLD:  phase_last = 8'(T_HOLD - 1);
            ST_REC:                 phase_last = 8'(T_REC - 1);
            default:                phase_last = 8'd0;
        endcase
    endfunction

    // The timer reloads on every state change with the new phase length.
    assign load     = (state_nx != state);
    assign load_val = phase_last(state_nx);

    rtc_phase_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .expired  (expired)
    );

    always_comb begin
        state_nx = state;
        op_nx    = op_q;
        dir_nx   = dir_q;
        dato_nx  = dato_q;
        case (state)
            ST_IDLE: begin
                if (escribe || lee_req) begin
                    state_nx = ST_A_SETUP;
                    op_nx    = escribe ? OP_WR : OP_RD;
                    dir_nx   = dir;
                    dato_nx  = dato;
                end
            end
            ST_A_SETUP: if (expired) state_nx = ST_A_PULSE;
            ST_A_PULSE: if (expired) state_nx = ST_A_HOLD;
            ST_A_HOLD:  if (expired) state_nx = ST_D_SETUP;
            ST_D_SETUP: if (expired) state_nx = ST_D_PULSE;
            ST_D_PULSE: if (expired) state_nx = ST_D_HOLD;
            ST_D_HOLD:  if (expired) state_nx = ST_DONE;
            ST_DONE:    state_nx = ST_REC;
            ST_REC:     if (expired) state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered outputs line
    // up with the state they belong to.
    always_comb begin
        cs_n_nx    = 1'b1;
        wr_n_nx    = 1'b1;
        rd_n_nx    = 1'b1;
        ad_oe_nx   = 1'b0;
        ad_sel_nx  = 1'b0;
        ad_out_nx  = 8'd0;
        fin_nx     = (state_nx == ST_DONE);
        ocupado_nx = (state_nx != ST_IDLE);
        case (state_nx)
            ST_A_SETUP, ST_A_PULSE, ST_A_HOLD: begin
                cs_n_nx   = 1'b0;
                ad_oe_nx  = 1'b1;
                ad_out_nx = dir_nx;
                wr_n_nx   = (state_nx != ST_A_PULSE);
            end
            ST_D_SETUP, ST_D_PULSE, ST_D_HOLD: begin
                cs_n_nx   = 1'b0;
                ad_sel_nx = 1'b1;
                if (op_nx == OP_WR) begin
                    ad_oe_nx  = 1'b1;
                    ad_out_nx = dato_nx;
                    wr_n_nx   = (state_nx != ST_D_PULSE);
                end else begin
                    rd_n_nx   = (state_nx != ST_D_PULSE);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            op_q    <= OP_WR;
            dir_q   <= 8'd0;
            dato_q  <= 8'd0;
            cs_n    <= 1'b1;
            wr_n    <= 1'b1;
            rd_n    <= 1'b1;
            ad_oe   <= 1'b0;
            ad_sel  <= 1'b0;
            ad_out  <= 8'd0;
            fin     <= 1'b0;
            ocupado <= 1'b0;
        end else begin
            state   <= state_nx;
            op_q    <= op_nx;
            dir_q   <= dir_nx;
            dato_q  <= dato_nx;
            cs_n    <= cs_n_nx;
            wr_n    <= wr_n_nx;
            rd_n    <= rd_n_nx;
            ad_oe   <= ad_oe_nx;
            ad_sel  <= ad_sel_nx;
            ad_out  <= ad_out_nx;
            fin     <= fin_nx;
            ocupado <= ocupado_nx;
        end
    end

`ifdef RTC_READ_EN
    // Capture on the edge that ends the last D_PULSE cycle, while rd_n is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dato_leido <= 8'd0;
        end else if (state == ST_D_PULSE && expired && op_q == OP_RD) begin
            dato_leido <= ad_in;
        end
    end
`else
    assign dato_leido = 8'd0;
    logic unused_rd;
    assign unused_rd = ^{lee, ad_in};
`endif

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
module tb_rtc_bus_ctrl;

    localparam int TS = 2;
    localparam int TP = 4;
    localparam int TH = 2;
    localparam int TR = 2;
    localparam int PH = TS + TP + TH;
    localparam int NK = 20;

    localparam int K_IDLE = 0;
    localparam int K_WR   = 1;
    localparam int K_RD   = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       escribe, lee;
    logic [7:0] dir, dato, ad_in;
    logic [7:0] ad_out, dato_leido;
    logic       ad_oe, ad_sel, cs_n, wr_n, rd_n, fin, ocupado;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rtc_bus_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .escribe    (escribe),
        .lee        (lee),
        .dir        (dir),
        .dato       (dato),
        .ad_in      (ad_in),
        .ad_out     (ad_out),
        .ad_oe      (ad_oe),
        .ad_sel     (ad_sel),
        .cs_n       (cs_n),
        .wr_n       (wr_n),
        .rd_n       (rd_n),
        .dato_leido (dato_leido),
        .fin        (fin),
        .ocupado    (ocupado)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NK:1] win(input int lo, input int hi);
        logic [NK:1] w;
        w = '0;
        for (int k = 1; k <= NK; k++)
            if (k >= lo && k <= hi) w[k] = 1'b1;
        return w;
    endfunction

    // Cycle k is the cycle after the k-th rising edge following the request
    // sample edge (k=0). Expected: cs_n low k=1..16, fin at k=17, REC k=18..19.
    task automatic txn(input string tag, input int kind, input int drop_at,
                       input int chg_at, input logic [7:0] chg_dir, input logic [7:0] chg_dato,
                       input logic [7:0] exp_a, input logic [7:0] exp_d,
                       input logic [7:0] rdval, input logic [7:0] exp_dl);
        logic [NK:1] cs, wr, rd, oe, sel, fn, oc;
        logic [NK:1] e_cs, e_wr, e_rd, e_oe, e_sel, e_fn, e_oc;
        logic [7:0]  ad_a, ad_d, dl;
        cs = '0; wr = '0; rd = '0; oe = '0; sel = '0; fn = '0; oc = '0;
        ad_a = '0; ad_d = '0; dl = '0;
        for (int k = 1; k <= NK; k++) begin
            @(negedge clk);
            if (k == drop_at) begin escribe = 1'b0; lee = 1'b0; end
            if (k == chg_at) begin dir = chg_dir; dato = chg_dato; end
            ad_in = (k >= PH + TS + 1 && k <= PH + TS + TP) ? rdval : 8'h5A;
            cs[k]  = ~cs_n;
            wr[k]  = ~wr_n;
            rd[k]  = ~rd_n;
            oe[k]  = ad_oe;
            sel[k] = ad_sel;
            fn[k]  = fin;
            oc[k]  = ocupado;
            if (k == TS + 1)      ad_a = ad_out;
            if (k == PH + TS + 1) ad_d = ad_out;
            if (k == 2 * PH + 1)  dl = dato_leido;
        end
        if (kind == K_IDLE) begin
            e_cs = '0; e_wr = '0; e_rd = '0; e_oe = '0; e_sel = '0; e_fn = '0; e_oc = '0;
        end else begin
            e_cs  = win(1, 2 * PH);
            e_wr  = win(TS + 1, TS + TP) | ((kind == K_WR) ? win(PH + TS + 1, PH + TS + TP) : '0);
            e_rd  = (kind == K_RD) ? win(PH + TS + 1, PH + TS + TP) : '0;
            e_oe  = (kind == K_WR) ? win(1, 2 * PH) : win(1, PH);
            e_sel = win(PH + 1, 2 * PH);
            e_fn  = win(2 * PH + 1, 2 * PH + 1);
            e_oc  = win(1, 2 * PH + 1 + TR);
        end
        chk({tag, "_cs_n"},    32'(cs),  32'(e_cs));
        chk({tag, "_wr_n"},    32'(wr),  32'(e_wr));
        chk({tag, "_rd_n"},    32'(rd),  32'(e_rd));
        chk({tag, "_ad_oe"},   32'(oe),  32'(e_oe));
        chk({tag, "_ad_sel"},  32'(sel), 32'(e_sel));
        chk({tag, "_fin"},     32'(fn),  32'(e_fn));
        chk({tag, "_ocupado"}, 32'(oc),  32'(e_oc));
        if (kind != K_IDLE) chk({tag, "_addr"}, 32'(ad_a), 32'(exp_a));
        if (kind == K_WR)   chk({tag, "_data"}, 32'(ad_d), 32'(exp_d));
        chk({tag, "_dato_leido"}, 32'(dl), 32'(exp_dl));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; escribe = 1'b0; lee = 1'b0;
        dir = 8'h00; dato = 8'h00; ad_in = 8'h00;

        // Reset state
        @(negedge clk);
        chk("rst_ctrl", 32'({cs_n, wr_n, rd_n, ad_oe, ad_sel, fin, ocupado}), 32'(7'b1110000));
        chk("rst_ad_out", 32'(ad_out), 32'h00);
        chk("rst_dato_leido", 32'(dato_leido), 32'h00);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // 1: plain write, request dropped right after sampling
        escribe = 1'b1; dir = 8'h21; dato = 8'h45;
        txn("t1", K_WR, 1, 0, 8'h00, 8'h00, 8'h21, 8'h45, 8'h00, 8'h00);

        // 3: request held, new dir/dato one cycle after fin
        escribe = 1'b1; dir = 8'h11; dato = 8'h22;
        txn("t3a", K_WR, 0, 2 * PH + 2, 8'hF0, 8'hF0, 8'h11, 8'h22, 8'h00, 8'h00);
        txn("t3b", K_WR, 1, 0, 8'h00, 8'h00, 8'hF0, 8'hF0, 8'h00, 8'h00);

        // 4: both requests together -> write wins
        escribe = 1'b1; lee = 1'b1; dir = 8'h33; dato = 8'h44;
        txn("t4", K_WR, 1, 0, 8'h00, 8'h00, 8'h33, 8'h44, 8'h00, 8'h00);

`ifdef RTC_READ_EN
        // 2: read
        lee = 1'b1; dir = 8'h22; dato = 8'h99;
        txn("t2", K_RD, 1, 0, 8'h00, 8'h00, 8'h22, 8'h00, 8'h37, 8'h37);
`else
        // 6: read request alone is ignored without the read path
        lee = 1'b1; dir = 8'h66; dato = 8'h99;
        txn("t6", K_IDLE, NK, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h37, 8'h00);
`endif

        // 5: asynchronous reset in A_PULSE
        escribe = 1'b1; dir = 8'h77; dato = 8'h88;
        @(negedge clk);
        escribe = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_in_pulse_wr_n", 32'(wr_n), 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("t5_async_ctrl", 32'({cs_n, wr_n, ad_oe, ocupado}), 32'(4'b1100));
        @(negedge clk);
        reset = 1'b1;
        begin
            logic seen_fin, seen_busy;
            seen_fin = 1'b0; seen_busy = 1'b0;
            for (int k = 0; k < NK; k++) begin
                @(negedge clk);
                seen_fin  = seen_fin | fin;
                seen_busy = seen_busy | ocupado;
            end
            chk("t5_no_fin", 32'(seen_fin), 32'd0);
            chk("t5_no_busy", 32'(seen_busy), 32'd0);
        end
        escribe = 1'b1; dir = 8'h5A; dato = 8'hA5;
        txn("t5_after", K_WR, 1, 0, 8'h00, 8'h00, 8'h5A, 8'hA5, 8'h00, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
